// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types for the cache sweep controller.
//   sweep_func_t  - sweep operation encoding as carried on the func port
//   sweep_state_t - sweep sequencer FSM states
package sweep_pkg;

  typedef enum logic [1:0] {
    SWP_VALIDATE   = 2'd0,
    SWP_UNLOAD     = 2'd1,
    SWP_UNLOAD_INV = 2'd2,
    SWP_INVAL      = 2'd3
  } sweep_func_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIR  = 3'd1,
    WB   = 3'd2,
    INV  = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } sweep_state_t;

endpackage

// File: rtl/sweep_addr_ctr.sv
// sweep_addr_ctr: line/way walker for the cache sweep.
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clr       - return to line 0 / way 0
//   i_adv       - step to the next entry (way first, then line)
//   o_line      - current line index (registered)
//   o_way       - current way index (registered)
//   o_last_c    - current entry is the final line/way (combinational)
module sweep_addr_ctr #(
  parameter int unsigned LINE_BITS = 7,
  parameter int unsigned WAY_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_adv,
  output logic [LINE_BITS-1:0] o_line,
  output logic [WAY_BITS-1:0]  o_way,
  output logic                 o_last_c
);

  logic [LINE_BITS-1:0] r_line;
  logic [WAY_BITS-1:0]  r_way;

  // Way advances first; the line steps when the way wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_way  <= '0;
    end else if (i_clr) begin
      r_line <= '0;
      r_way  <= '0;
    end else if (i_adv) begin
      if (r_way == '1) begin
        r_way  <= '0;
        r_line <= r_line + LINE_BITS'(1);
      end else begin
        r_way <= r_way + WAY_BITS'(1);
      end
    end
  end

  assign o_line   = r_line;
  assign o_way    = r_way;
  assign o_last_c = (&r_line) & (&r_way);

endmodule

// File: rtl/csh_sweep_ctl.sv
// csh_sweep_ctl: sequences a full cache sweep (validate / unload / invalidate)
// over every line of every way, using req/ack handshakes to the cache
// directory, writeback and invalidate paths.
//   clk, RESET_N          - clock, asynchronous active-low reset
//   start, func           - sweep command strobe and operation
//   page_en, page         - optional page restriction (sampled at start)
//   abort                 - stop at the next entry boundary
//   dir_req/dir_ack       - directory read; dir_valid/dir_written/dir_tag with ack
//   wb_req/wb_ack         - writeback handshake
//   inv_req/inv_ack       - invalidate handshake
//   line, way             - current entry
//   sweep_busy/sweep_done - busy level and one-cycle completion pulse
//   count                 - lines written back this sweep (saturating)
module csh_sweep_ctl
  import sweep_pkg::*;
#(
  parameter int unsigned LINE_BITS = 7,
  parameter int unsigned WAY_BITS  = 2,
  parameter int unsigned PAGE_BITS = 9
) (
  input  logic                        clk,
  input  logic                        RESET_N,
  input  logic                        start,
  input  logic [1:0]                  func,
  input  logic                        page_en,
  input  logic [PAGE_BITS-1:0]        page,
  input  logic                        abort,
  output logic                        dir_req,
  input  logic                        dir_ack,
  input  logic                        dir_valid,
  input  logic                        dir_written,
  input  logic [PAGE_BITS-1:0]        dir_tag,
  output logic                        wb_req,
  input  logic                        wb_ack,
  output logic                        inv_req,
  input  logic                        inv_ack,
  output logic [LINE_BITS-1:0]        line,
  output logic [WAY_BITS-1:0]         way,
  output logic                        sweep_busy,
  output logic                        sweep_done,
  output logic [LINE_BITS+WAY_BITS:0] count
);

  localparam int unsigned CNT_BITS = LINE_BITS + WAY_BITS + 1;

  sweep_state_t         r_state;
  sweep_state_t         w_state_nxt;
  sweep_func_t          r_func;
  logic                 r_page_en;
  logic [PAGE_BITS-1:0] r_page;
  logic                 r_abort;
  logic                 r_need_inv;
  logic [CNT_BITS-1:0]  r_count;
  logic                 r_dir_req;
  logic                 r_wb_req;
  logic                 r_inv_req;
  logic                 r_busy;
  logic                 r_done;

  logic w_hit;
  logic w_need_wb;
  logic w_need_inv;
  logic w_last;
  logic w_finish;
  logic w_clr;
  logic w_adv;
  logic w_cnt_inc;
  logic w_dir_req_d;
  logic w_wb_req_d;
  logic w_inv_req_d;
  logic w_busy_d;
  logic w_done_d;

  sweep_addr_ctr #(
    .LINE_BITS (LINE_BITS),
    .WAY_BITS  (WAY_BITS)
  ) u_addr_ctr (
    .clk      (clk),
    .rst_n    (RESET_N),
    .i_clr    (w_clr),
    .i_adv    (w_adv),
    .o_line   (line),
    .o_way    (way),
    .o_last_c (w_last)
  );

  // Line classification from the directory response.
  assign w_hit      = dir_valid & (~r_page_en | (dir_tag == r_page));
  assign w_need_wb  = w_hit & dir_written & (r_func != SWP_INVAL);
  assign w_need_inv = w_hit & ((r_func == SWP_UNLOAD_INV) | (r_func == SWP_INVAL));
  // An abort arriving in the NEXT cycle itself also ends the sweep.
  assign w_finish   = r_abort | abort | w_last;

  // State register.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = DIR;
      DIR: begin
        if (dir_ack) begin
          if (w_need_wb)       w_state_nxt = WB;
          else if (w_need_inv) w_state_nxt = INV;
          else                 w_state_nxt = NEXT;
        end
      end
      WB:   if (wb_ack)  w_state_nxt = r_need_inv ? INV : NEXT;
      INV:  if (inv_ack) w_state_nxt = NEXT;
      NEXT: w_state_nxt = w_finish ? DONE : DIR;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/control decode; port outputs are registered from the next state.
  always_comb begin
    w_clr       = (r_state == IDLE) & start;
    w_adv       = (r_state == NEXT) & ~w_finish;
    w_cnt_inc   = (r_state == WB) & wb_ack & (r_count != '1);
    w_dir_req_d = (w_state_nxt == DIR);
    w_wb_req_d  = (w_state_nxt == WB);
    w_inv_req_d = (w_state_nxt == INV);
    w_done_d    = (w_state_nxt == DONE);
    w_busy_d    = (w_state_nxt == DIR) | (w_state_nxt == WB) |
                  (w_state_nxt == INV) | (w_state_nxt == NEXT);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dir_req <= 1'b0;
      r_wb_req  <= 1'b0;
      r_inv_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_dir_req <= w_dir_req_d;
      r_wb_req  <= w_wb_req_d;
      r_inv_req <= w_inv_req_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  // Command latch, sticky abort, per-entry invalidate flag and writeback count.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_func     <= SWP_VALIDATE;
      r_page_en  <= 1'b0;
      r_page     <= '0;
      r_abort    <= 1'b0;
      r_need_inv <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_clr) begin
        r_func    <= sweep_func_t'(func);
        r_page_en <= page_en;
        r_page    <= page;
      end
      if (r_state == IDLE) r_abort <= 1'b0;
      else if (abort)      r_abort <= 1'b1;
      if ((r_state == DIR) && dir_ack) r_need_inv <= w_need_inv;
      if (w_clr)          r_count <= '0;
      else if (w_cnt_inc) r_count <= r_count + CNT_BITS'(1);
    end
  end

  assign dir_req    = r_dir_req;
  assign wb_req     = r_wb_req;
  assign inv_req    = r_inv_req;
  assign sweep_busy = r_busy;
  assign sweep_done = r_done;
  assign count      = r_count;

endmodule

// File: tb/tb_csh_sweep_ctl.sv
// tb_csh_sweep_ctl: directed bench for csh_sweep_ctl on a 4-line x 2-way cache.
// Expected writeback/invalidate events are queued from a directory model when a
// sweep is started and popped as the DUT completes each handshake.
module tb_csh_sweep_ctl;

  localparam int unsigned LBITS = 2;
  localparam int unsigned WBITS = 1;
  localparam int unsigned PB    = 9;
  localparam int unsigned NENT  = 8;

  typedef struct packed {
    logic [1:0]       kind;   // 1 = writeback, 2 = invalidate
    logic [LBITS-1:0] ln;
    logic [WBITS-1:0] wy;
  } ev_t;

  logic             clk;
  logic             RESET_N;
  logic             start;
  logic [1:0]       func;
  logic             page_en;
  logic [PB-1:0]    page;
  logic             abort;
  logic             dir_req, dir_ack, dir_valid, dir_written;
  logic [PB-1:0]    dir_tag;
  logic             wb_req, wb_ack, inv_req, inv_ack;
  logic [LBITS-1:0] line;
  logic [WBITS-1:0] way;
  logic             sweep_busy, sweep_done;
  logic [LBITS+WBITS:0] count;

  logic          m_vld [NENT];
  logic          m_wr  [NENT];
  logic [PB-1:0] m_tag [NENT];
  logic [2:0]    w_idx;
  logic          ack_en, rand_mode, blk_en;
  logic [2:0]    blk_idx;

  ev_t sb[$];
  int  vec, err, cyc, c0, done_cyc, n_done, n_dir, n_wb;

  csh_sweep_ctl #(.LINE_BITS(LBITS), .WAY_BITS(WBITS), .PAGE_BITS(PB)) dut (
    .clk(clk), .RESET_N(RESET_N), .start(start), .func(func),
    .page_en(page_en), .page(page), .abort(abort),
    .dir_req(dir_req), .dir_ack(dir_ack), .dir_valid(dir_valid),
    .dir_written(dir_written), .dir_tag(dir_tag),
    .wb_req(wb_req), .wb_ack(wb_ack), .inv_req(inv_req), .inv_ack(inv_ack),
    .line(line), .way(way), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Directory/ack responder; blk_en stalls the writeback of one entry.
  assign w_idx       = {line, way};
  assign dir_valid   = m_vld[w_idx];
  assign dir_written = m_wr[w_idx];
  assign dir_tag     = m_tag[w_idx];
  assign dir_ack     = dir_req & ack_en;
  assign wb_ack      = wb_req & ack_en & ~(blk_en & (w_idx == blk_idx));
  assign inv_ack     = inv_req & ack_en;

  always begin
    @(posedge clk);
    #1;
    ack_en = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input logic [1:0] kind);
    ev_t obs;
    ev_t exp;
    obs = {kind, line, way};
    chk("sb_underflow", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      chk("sb_event", 32'(obs), 32'(exp));
    end
  endtask

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (RESET_N) begin
      chk("one_req", 32'($countones({dir_req, wb_req, inv_req}) <= 1), 32'd1);
      if (sweep_done) begin
        n_done++;
        done_cyc = cyc;
        chk("busy_at_done", 32'(sweep_busy), 32'd0);
      end
      if (dir_req && dir_ack) n_dir++;
      if (wb_req && wb_ack)   sb_pop(2'd1);
      if (inv_req && inv_ack) sb_pop(2'd2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk entries in order (way fastest), stopping after stop_idx.
  task automatic push_model(input logic [1:0] f, input logic pe,
                            input logic [PB-1:0] pg, input int stop_idx);
    n_wb = 0;
    for (int i = 0; i < NENT && i <= stop_idx; i++) begin
      logic hit, nwb, ninv;
      ev_t  e;
      hit  = m_vld[i] && (!pe || (m_tag[i] == pg));
      nwb  = hit && m_wr[i] && (f != 2'd3);
      ninv = hit && ((f == 2'd2) || (f == 2'd3));
      e.ln = LBITS'(i >> WBITS);
      e.wy = WBITS'(i);
      if (nwb)  begin e.kind = 2'd1; sb.push_back(e); n_wb++; end
      if (ninv) begin e.kind = 2'd2; sb.push_back(e); end
    end
  endtask

  task automatic fill(input logic v, input logic w);
    for (int i = 0; i < NENT; i++) begin
      m_vld[i] = v;
      m_wr[i]  = w;
      m_tag[i] = '0;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NENT; i++) begin
      m_vld[i] = 1'($urandom_range(0, 1));
      m_wr[i]  = 1'($urandom_range(0, 1));
      m_tag[i] = PB'($urandom_range(0, 511));
    end
  endtask

  task automatic do_start(input logic [1:0] f, input logic pe, input logic [PB-1:0] pg);
    n_done = 0;
    n_dir  = 0;
    func    = f;
    page_en = pe;
    page    = pg;
    start   = 1'b1;
    c0      = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    chk("done_timeout", 32'(n_done != 0), 32'd1);
    repeat (3) tick();
    chk("done_once", 32'(n_done), 32'd1);
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_wb(input logic [LBITS-1:0] ln, input logic [WBITS-1:0] wy, input int budget);
    int k = 0;
    while (!(wb_req && line == ln && way == wy) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_wb", 32'(wb_req && line == ln && way == wy), 32'd1);
  endtask

  initial begin
    vec = 0; err = 0; cyc = 0; c0 = 0; done_cyc = 0;
    n_done = 0; n_dir = 0; n_wb = 0;
    RESET_N = 1'b0; start = 1'b0; func = '0; page_en = 1'b0; page = '0; abort = 1'b0;
    ack_en = 1'b1; rand_mode = 1'b0; blk_en = 1'b0; blk_idx = '0;
    fill(1'b0, 1'b0);

    // Reset state.
    repeat (3) tick();
    chk("reset_outs", 32'({dir_req, wb_req, inv_req, line, way, sweep_busy, sweep_done, count}), 32'd0);
    RESET_N = 1'b1;
    tick();

    // No hits: 2 cycles per entry plus one, start to done pulse.
    push_model(2'd0, 1'b0, '0, 99);
    do_start(2'd0, 1'b0, '0);
    wait_done(200);
    chk("lat_nohit", 32'(done_cyc - c0), 32'd17);
    chk("cnt_nohit", 32'(count), 32'd0);
    chk("dir_nohit", 32'(n_dir), 32'd8);

    // Unload, every line valid and written.
    fill(1'b1, 1'b1);
    push_model(2'd1, 1'b0, '0, 99);
    do_start(2'd1, 1'b0, '0);
    chk("busy_after_start", 32'(sweep_busy), 32'd1);
    wait_done(200);
    chk("cnt_unload", 32'(count), 32'd8);
    chk("busy_idle", 32'(sweep_busy), 32'd0);

    // Unload+invalidate, only line 3 way 1 dirty.
    fill(1'b0, 1'b0);
    m_vld[7] = 1'b1;
    m_wr[7]  = 1'b1;
    push_model(2'd2, 1'b0, '0, 99);
    do_start(2'd2, 1'b0, '0);
    wait_done(200);
    chk("cnt_one", 32'(count), 32'd1);

    // Invalidate-only with page match; page inputs change after start.
    fill(1'b1, 1'b1);
    for (int i = 0; i < NENT; i++) m_tag[i] = (i % 2 == 0) ? PB'(5) : PB'(6);
    push_model(2'd3, 1'b1, PB'(5), 99);
    do_start(2'd3, 1'b1, PB'(5));
    page_en = 1'b0;
    page    = PB'(6);
    wait_done(200);
    chk("cnt_inval", 32'(count), 32'd0);

    // Abort while writeback of line 1 way 0 is stalled.
    fill(1'b1, 1'b1);
    blk_en  = 1'b1;
    blk_idx = 3'd2;
    push_model(2'd1, 1'b0, '0, 2);
    do_start(2'd1, 1'b0, '0);
    wait_wb(2'd1, 1'b0, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("wb_held", 32'({wb_req, line, way}), 32'({1'b1, 2'd1, 1'b0}));
    blk_en = 1'b0;
    wait_done(200);
    chk("dir_abort", 32'(n_dir), 32'd3);
    chk("cnt_abort", 32'(count), 32'd3);

    // Asynchronous reset in the middle of a writeback.
    blk_en  = 1'b1;
    blk_idx = 3'd3;
    do_start(2'd1, 1'b0, '0);
    sb.delete();
    push_model(2'd1, 1'b0, '0, 99);
    wait_wb(2'd1, 1'b1, 100);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("reset_mid_wb", 32'({dir_req, wb_req, inv_req, line, way, sweep_busy, sweep_done, count}), 32'd0);
    chk("reset_no_done", 32'(n_done), 32'd0);
    sb.delete();
    blk_en = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    push_model(2'd1, 1'b0, '0, 99);
    do_start(2'd1, 1'b0, '0);
    chk("restart_first", 32'({dir_req, line, way}), 32'({1'b1, 2'd0, 1'b0}));
    wait_done(200);
    chk("cnt_restart", 32'(count), 32'd8);

    // Start while busy with a different func is ignored; random ack waits.
    fill_rand();
    rand_mode = 1'b1;
    push_model(2'd0, 1'b0, '0, 99);
    do_start(2'd0, 1'b0, '0);
    repeat (5) tick();
    func  = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2000);
    chk("cnt_busy_start", 32'(count), 32'(n_wb));

    // Start and abort in the same idle cycle: abort is discarded.
    fill_rand();
    push_model(2'd2, 1'b0, '0, 99);
    abort = 1'b1;
    do_start(2'd2, 1'b0, '0);
    abort = 1'b0;
    wait_done(2000);
    chk("dir_start_abort", 32'(n_dir), 32'd8);
    chk("cnt_start_abort", 32'(count), 32'(n_wb));
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/csh_sweep_ctl.md
Name: csh_sweep_ctl

Overview:
- Sequences a full cache sweep (validate, unload, invalidate) on behalf of the APR.
- Started by a CONO/DATAO-decoded sweep command from CON/MCL.
- Walks every line of every way, querying the MBOX cache directory and issuing writeback/invalidate requests through a req/ack handshake.
- Drives SWEEP_BUSY into APR, whose SWEEP_DONE event flag sets on busy's falling edge; also emits a one-cycle done pulse.

Parameters:
- LINE_BITS, 7, line index width (128 lines per way).
- WAY_BITS, 2, way index width (4 ways).
- PAGE_BITS, 9, width of the page tag used in page-restricted sweeps.

Ports:
- clk  in  1  EBOX clock (CLK.APR domain).
- RESET_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle sweep command strobe.
- func  in  2  sweep op: 0=validate-core, 1=unload, 2=unload+invalidate, 3=invalidate-only.
- page_en  in  1  restrict sweep to lines whose tag equals page; sampled at start.
- page  in  PAGE_BITS  target page, sampled at start.
- abort  in  1  terminate sweep at the next entry boundary.
- dir_req  out  1  directory read request.
- dir_ack  in  1  directory read complete; status valid this cycle.
- dir_valid, dir_written  in  1 each  line status returned with dir_ack.
- dir_tag  in  PAGE_BITS  line tag returned with dir_ack.
- wb_req  out  1  write line back to core.
- wb_ack  in  1  writeback complete.
- inv_req  out  1  clear line valid.
- inv_ack  in  1  invalidate complete.
- line  out  LINE_BITS  current line index.
- way  out  WAY_BITS  current way index.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse on completion or abort.
- count  out  LINE_BITS+WAY_BITS+1  number of lines written back this sweep.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, line=way=0, count=0. Asynchronous reset also takes effect mid-sweep; no done pulse is produced.
- FSM states and transitions:
  - IDLE: on start, latch func/page_en/page, clear line/way/count, go to DIR. sweep_busy=1 from the cycle after start.
  - DIR: assert dir_req until dir_ack (minimum 1 cycle). On ack, evaluate:
    - hit = dir_valid & (~page_en | dir_tag==page).
    - Needs writeback: hit & dir_written & func∈{0,1,2}.
    - Needs invalidate: hit & func∈{2,3}.
    - Go to WB if writeback is needed, else INV if invalidate is needed, else NEXT.
  - WB: hold wb_req until wb_ack; count+=1 (saturating at all-ones). Then go to INV if invalidate is needed, else NEXT.
  - INV: hold inv_req until inv_ack, then go to NEXT.
  - NEXT: one cycle. If abort is latched or line/way is at last, go to DONE. Else advance way first; when way wraps, increment line. Go to DIR.
  - DONE: sweep_busy=0, sweep_done=1 for exactly one cycle, then IDLE.
- Only one of dir_req/wb_req/inv_req is asserted at a time.
- Requests are held stable (line/way unchanged) until the matching ack.
- An ack arriving in a state that does not expect it is ignored.
- start while busy is ignored; func/page are not re-latched.
- abort is latched (sticky) in any busy state. The current entry completes its pending handshakes; DONE follows the next NEXT. abort in IDLE is ignored. The sticky abort clears in IDLE.
- start and abort in the same IDLE cycle: the sweep starts and abort is discarded.
- func=3 never issues wb_req, even for written lines (data discarded by design).
- Last entry: line=2^LINE_BITS-1 and way=2^WAY_BITS-1. No wrap back to 0 after it.
- Latency with zero-wait acks:
  - Clean unmatched line: 2 cycles (DIR+NEXT).
  - Full sweep, no hits: 2*2^(LINE_BITS+WAY_BITS)+1 cycles from start to the sweep_done pulse.

Decomposition:
- Package sweep_pkg: sweep_func_t enum (SWP_VALIDATE, SWP_UNLOAD, SWP_UNLOAD_INV, SWP_INVAL) and sweep_state_t enum (IDLE, DIR, WB, INV, NEXT, DONE).
- One natural sub-module: sweep_addr_ctr, the line/way counter with clear, advance and last flag.

Test Plan:
- Reset mid-WB (RESET_N low while wb_req=1) -> all outputs 0 immediately; no sweep_done; next start begins at line 0 way 0.
- func=1, all dirs valid & written, zero-wait acks, LINE_BITS=2/WAY_BITS=1 -> 8 wb_req, 0 inv_req, count=8, single sweep_done pulse, busy low same cycle as done.
- func=2, line3 way1 valid & written, others invalid -> exactly one wb_req then one inv_req, both at line=3 way=1; count=1.
- func=3, page_en=1, page=0x05, tags alternate 0x05/0x06 all valid & written -> inv_req only on 0x05 lines; no wb_req; count=0.
- abort asserted during WB at line 1 -> wb completes, NEXT, DONE; no further dir_req; sweep_done pulses once.
- start pulsed while busy with func changed -> ignored; original func behaviour persists; start and abort together in IDLE -> sweep runs to completion.
